// File: rtl/baopoco_delay_loader.sv
// baopoco_delay_loader
//   Sync-aligned loader for per-antenna coarse delays. A command word from the
//   delay_data software register is decoded on the rising edge of its load bit.
//   The word is range-checked, and the antenna/delay pair is held pending until
//   the next pipeline sync pulse, or applied at once when the immediate bit is set.
//   Applying a load writes the internal per-antenna delay table and issues a
//   one-cycle write strobe to the downstream coarse-delay buffers.
//
// Ports:
//   user_clk    in   sole clock, rising edge
//   user_rst_n  in   asynchronous active-low reset
//   delay_data  in   [31] load, [30] immediate, [29] err_clr, [19:16] antenna,
//                    [DELAY_W-1:0] delay
//   sync_in     in   one-cycle pipeline sync pulse
//   rd_addr     in   table read address
//   rd_delay    out  table[rd_addr], one-cycle latency
//   delay_we    out  one-cycle write strobe to the coarse-delay stage
//   delay_addr  out  antenna being written (holds when delay_we=0)
//   delay_val   out  delay being written (holds when delay_we=0)
//   pending     out  a load is captured and waiting for sync
//   load_cnt    out  count of applied loads, wrapping
//   err         out  sticky: rejected antenna or clamped delay
module baopoco_delay_loader #(
    parameter int N_ANT     = 8,
    parameter int ANT_W     = 3,
    parameter int DELAY_W   = 12,
    parameter int MAX_DELAY = 2047
) (
    input  logic               user_clk,
    input  logic               user_rst_n,
    input  logic [31:0]        delay_data,
    input  logic               sync_in,
    input  logic [ANT_W-1:0]   rd_addr,
    output logic [DELAY_W-1:0] rd_delay,
    output logic               delay_we,
    output logic [ANT_W-1:0]   delay_addr,
    output logic [DELAY_W-1:0] delay_val,
    output logic               pending,
    output logic [15:0]        load_cnt,
    output logic               err
);

    typedef enum logic [1:0] {IDLE, PEND, APPLY} state_t;

    // Saturate a requested delay to the largest legal value.
    function automatic logic [DELAY_W-1:0] clamp_delay(input logic [DELAY_W-1:0] raw);
        if (int'(raw) > MAX_DELAY) return DELAY_W'(MAX_DELAY);
        return raw;
    endfunction

    function automatic logic delay_over(input logic [DELAY_W-1:0] raw);
        return int'(raw) > MAX_DELAY;
    endfunction

    state_t             state_q, state_d;
    logic               load_prev_q, load_prev_d;
    logic               clr_prev_q, clr_prev_d;
    logic [ANT_W-1:0]   pend_addr_q, pend_addr_d;
    logic [DELAY_W-1:0] pend_val_q, pend_val_d;
    logic               delay_we_q, delay_we_d;
    logic [ANT_W-1:0]   delay_addr_q, delay_addr_d;
    logic [DELAY_W-1:0] delay_val_q, delay_val_d;
    logic [15:0]        load_cnt_q, load_cnt_d;
    logic               err_q, err_d;
    logic [DELAY_W-1:0] rd_delay_q, rd_delay_d;
    logic [DELAY_W-1:0] dly_tbl_q [N_ANT];
    logic [DELAY_W-1:0] dly_tbl_d [N_ANT];

    logic               load_edge, clr_edge, ant_ok, accept, imm;
    logic [3:0]         ant_f;
    logic [DELAY_W-1:0] raw_f;

    always_comb begin
        // Edge detectors reset to 1, so a bit held high through reset never fires.
        load_edge   = delay_data[31] & ~load_prev_q;
        clr_edge    = delay_data[29] & ~clr_prev_q;
        imm         = delay_data[30];
        ant_f       = delay_data[19:16];
        raw_f       = delay_data[DELAY_W-1:0];
        ant_ok      = int'(ant_f) < N_ANT;
        accept      = load_edge & ant_ok;

        load_prev_d  = delay_data[31];
        clr_prev_d   = delay_data[29];
        state_d      = state_q;
        pend_addr_d  = pend_addr_q;
        pend_val_d   = pend_val_q;
        delay_we_d   = 1'b0;
        delay_addr_d = delay_addr_q;
        delay_val_d  = delay_val_q;
        load_cnt_d   = load_cnt_q;
        err_d        = err_q;
        dly_tbl_d    = dly_tbl_q;
        rd_delay_d   = (int'(rd_addr) < N_ANT) ? dly_tbl_q[rd_addr] : '0;

        if (accept) begin
            pend_addr_d = ANT_W'(ant_f);
            pend_val_d  = clamp_delay(raw_f);
        end

        // A coincident sync in IDLE/PEND is never used for the load captured
        // in the same cycle: an accepted load takes priority over sync.
        case (state_q)
            IDLE: begin
                if (accept) state_d = imm ? APPLY : PEND;
            end
            PEND: begin
                if (accept)       state_d = imm ? APPLY : PEND;
                else if (sync_in) state_d = APPLY;
            end
            APPLY: begin
                dly_tbl_d[delay_addr_q] = delay_val_q;
                load_cnt_d              = load_cnt_q + 16'd1;
                if (accept) state_d = imm ? APPLY : PEND;
                else        state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Strobe and write data are registered so they coincide with APPLY.
        if (state_d == APPLY) begin
            delay_we_d   = 1'b1;
            delay_addr_d = pend_addr_d;
            delay_val_d  = pend_val_d;
        end

        // Clear first so a same-cycle new error wins.
        if (clr_edge) err_d = 1'b0;
        if (load_edge && (!ant_ok || delay_over(raw_f))) err_d = 1'b1;
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q      <= IDLE;
            load_prev_q  <= 1'b1;
            clr_prev_q   <= 1'b1;
            pend_addr_q  <= '0;
            pend_val_q   <= '0;
            delay_we_q   <= 1'b0;
            delay_addr_q <= '0;
            delay_val_q  <= '0;
            load_cnt_q   <= '0;
            err_q        <= 1'b0;
            rd_delay_q   <= '0;
            for (int i = 0; i < N_ANT; i++) dly_tbl_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            load_prev_q  <= load_prev_d;
            clr_prev_q   <= clr_prev_d;
            pend_addr_q  <= pend_addr_d;
            pend_val_q   <= pend_val_d;
            delay_we_q   <= delay_we_d;
            delay_addr_q <= delay_addr_d;
            delay_val_q  <= delay_val_d;
            load_cnt_q   <= load_cnt_d;
            err_q        <= err_d;
            rd_delay_q   <= rd_delay_d;
            for (int i = 0; i < N_ANT; i++) dly_tbl_q[i] <= dly_tbl_d[i];
        end
    end

    assign rd_delay   = rd_delay_q;
    assign delay_we   = delay_we_q;
    assign delay_addr = delay_addr_q;
    assign delay_val  = delay_val_q;
    assign pending    = (state_q == PEND);
    assign load_cnt   = load_cnt_q;
    assign err        = err_q;

endmodule

// File: tb/tb_baopoco_delay_loader.sv
// Scoreboard bench for baopoco_delay_loader: stimulus pushes the expected
// write (addr, val, cycle) into a queue; a negedge monitor pops and compares
// whenever delay_we is high.
module tb_baopoco_delay_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] delay_data;
    logic        sync_in;
    logic [2:0]  rd_addr;
    logic [11:0] rd_delay;
    logic        delay_we;
    logic [2:0]  delay_addr;
    logic [11:0] delay_val;
    logic        pending;
    logic [15:0] load_cnt;
    logic        err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int addr;
        int val;
        int cyc;
    } exp_t;
    exp_t exp_q[$];

    baopoco_delay_loader #(
        .N_ANT(8), .ANT_W(3), .DELAY_W(12), .MAX_DELAY(2047)
    ) dut (
        .user_clk   (clk),
        .user_rst_n (rst_n),
        .delay_data (delay_data),
        .sync_in    (sync_in),
        .rd_addr    (rd_addr),
        .rd_delay   (rd_delay),
        .delay_we   (delay_we),
        .delay_addr (delay_addr),
        .delay_val  (delay_val),
        .pending    (pending),
        .load_cnt   (load_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; cyc then names the cycle.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input int addr, input int val);
        exp_t e;
        e.addr = addr;
        e.val  = val;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && delay_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", int'(delay_addr), -1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("write_addr", int'(delay_addr), e.addr);
                chk("write_val", int'(delay_val), e.val);
                chk("write_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        delay_data = 32'h8000_0000;
        sync_in    = 1'b0;
        rd_addr    = 3'd0;
        tick(3);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_pending", pending, 0);
        chk("rst_load_cnt", load_cnt, 0);
        chk("rst_err", err, 0);
        chk("rst_delay_we", delay_we, 0);
        chk("rst_delay_addr", delay_addr, 0);
        chk("rst_delay_val", delay_val, 0);
        chk("rst_rd_delay", rd_delay, 0);
        tick(4);
        chk("held_load_no_pending", pending, 0);

        // Synced load: ant 3, 0x123
        delay_data = 32'h0000_0000; tick(1);
        delay_data = 32'h8003_0123; tick(1);
        @(negedge clk);
        chk("synced_pending", pending, 1);
        tick(2);
        chk("synced_pending_hold", pending, 1);
        sync_in = 1'b1; expect_write(3, 12'h123); tick(1);
        sync_in = 1'b0;
        tick(1);
        chk("synced_load_cnt", load_cnt, 1);
        chk("synced_pending_clr", pending, 0);
        chk("addr_holds", delay_addr, 3);
        chk("val_holds", delay_val, 12'h123);
        rd_addr = 3'd3; tick(1);
        @(negedge clk);
        chk("rd_ant3", rd_delay, 12'h123);

        // Immediate load: ant 5, 1024
        delay_data = 32'h0000_0000; tick(1);
        delay_data = 32'hC005_0400; expect_write(5, 12'h400); tick(1);
        @(negedge clk);
        chk("imm_pending", pending, 0);
        tick(1);
        chk("imm_pending_after", pending, 0);
        chk("imm_load_cnt", load_cnt, 2);

        // Rejected antenna index
        delay_data = 32'h0000_0000; tick(1);
        delay_data = 32'h8009_0010; tick(1);
        @(negedge clk);
        chk("bad_ant_err", err, 1);
        chk("bad_ant_pending", pending, 0);
        tick(2);
        chk("bad_ant_load_cnt", load_cnt, 2);
        delay_data = 32'h2000_0000; tick(1);
        @(negedge clk);
        chk("err_clear", err, 0);

        // Clamped delay, synced
        delay_data = 32'h0000_0000; tick(1);
        delay_data = 32'h8001_0FFF; tick(1);
        @(negedge clk);
        chk("clamp_err", err, 1);
        chk("clamp_pending", pending, 1);
        tick(1);
        sync_in = 1'b1; expect_write(1, 2047); tick(1);
        sync_in = 1'b0;
        tick(1);
        chk("clamp_load_cnt", load_cnt, 3);
        chk("clamp_err_sticky", err, 1);
        delay_data = 32'h2000_0000; tick(1);
        @(negedge clk);
        chk("err_clear2", err, 0);

        // Latest wins; second edge coincides with a sync that must not apply it
        delay_data = 32'h0000_0000; tick(1);
        delay_data = 32'h8002_0010; tick(1);
        delay_data = 32'h0000_0000; tick(1);
        delay_data = 32'h8002_0020; sync_in = 1'b1; tick(1);
        sync_in = 1'b0;
        @(negedge clk);
        chk("coincident_pending", pending, 1);
        tick(3);
        chk("coincident_no_write_cnt", load_cnt, 3);
        sync_in = 1'b1; expect_write(2, 12'h020); tick(1);
        sync_in = 1'b0;
        tick(1);
        chk("latest_load_cnt", load_cnt, 4);
        rd_addr = 3'd2; tick(1);
        @(negedge clk);
        chk("rd_ant2", rd_delay, 12'h020);
        rd_addr = 3'd1; tick(1);
        @(negedge clk);
        chk("rd_ant1", rd_delay, 2047);
        rd_addr = 3'd5; tick(1);
        @(negedge clk);
        chk("rd_ant5", rd_delay, 12'h400);

        // Reset while pending discards the load and clears the table
        delay_data = 32'h0000_0000; tick(1);
        delay_data = 32'h8004_0055; tick(1);
        @(negedge clk);
        chk("pre_reset_pending", pending, 1);
        rst_n = 1'b0;
        #1;
        chk("reset_pending", pending, 0);
        chk("reset_load_cnt", load_cnt, 0);
        chk("reset_rd_delay", rd_delay, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        sync_in = 1'b1; tick(1);
        sync_in = 1'b0;
        tick(3);
        chk("post_reset_pending", pending, 0);
        chk("post_reset_load_cnt", load_cnt, 0);
        rd_addr = 3'd3; tick(1);
        @(negedge clk);
        chk("post_reset_rd_ant3", rd_delay, 0);
        rd_addr = 3'd2; tick(1);
        @(negedge clk);
        chk("post_reset_rd_ant2", rd_delay, 0);

        tick(2);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
